// File: rtl/axi4_wr_slave_mem.sv
// ---------------------------------------------------------------------------
// axi4_wr_slave_mem
//
// AXI4 write-only slave backed by an internal word-addressed memory. One burst
// is serviced at a time: address phase (IDLE), data beats (DATA), then a single
// write response (RESP). Bursts with an unsupported size or burst type are
// still fully consumed, but they write nothing and answer SLVERR.
//
// Optional feature (macro AXI4_WR_SLAVE_WLAST_CHK_EN):
//   When defined, a wlast that disagrees with the beat count (set early, or
//   missing on the final beat) turns the burst into an error. The offending
//   beat and all later beats are not written. Burst length still comes from
//   awlen. When undefined, wlast is ignored.
//
// Ports:
//   aclk, areset_n         clock, synchronous active-low reset
//   awvalid/awready        address handshake; awid, awaddr, awlen, awsize,
//                          awburst carry the burst description
//   wvalid/wready          data handshake; wdata, wstrb, wlast per beat
//   bvalid/bready          response handshake; bid, bresp (00 OKAY, 10 SLVERR)
//   mem_raddr, mem_rdata   combinational backdoor read of the memory
// ---------------------------------------------------------------------------
module axi4_wr_slave_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int STRB     = DATA_WIDTH / 8;
  localparam int SIZE_LOG = $clog2(STRB);
  localparam int AW       = $clog2(MEM_DEPTH);

  localparam logic [2:0] SIZE_CODE   = 3'(SIZE_LOG);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic                  out_of_reset;
  logic [ID_WIDTH-1:0]   id_q;
  logic [AW-1:0]         index;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            burst_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;
  logic aw_err;
  logic wlast_err;
  logic beat_err;
  logic write_en;
  logic unused_bits;

  // awready is held low through reset and for the reset edge itself; the
  // out_of_reset flag raises it on the first cycle after release.
  assign awready = out_of_reset && (state == ST_IDLE);
  assign wready  = (state == ST_DATA);
  assign bvalid  = (state == ST_RESP);

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign last_beat = (beat_cnt == len_q);

  // Only full-width beats and FIXED/INCR bursts are supported; WRAP and the
  // reserved encoding share the top awburst bit.
  assign aw_err = (awsize != SIZE_CODE) || awburst[1];

`ifdef AXI4_WR_SLAVE_WLAST_CHK_EN
  assign wlast_err   = (wlast != last_beat);
  assign unused_bits = ^awaddr;
`else
  assign wlast_err   = 1'b0;
  assign unused_bits = ^{awaddr, wlast};
`endif

  // A beat is dropped if the burst is already in error or this beat itself
  // breaks the wlast rule; an in-flight beat is also dropped on a reset edge.
  assign beat_err = err_q || wlast_err;
  assign write_en = w_hs && !beat_err && areset_n;

  // Burst control FSM: captures the address phase, walks the word index and
  // beat counter through the data phase, and holds the response until bready.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state        <= ST_IDLE;
      out_of_reset <= 1'b0;
      id_q         <= '0;
      index        <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      bid          <= '0;
      bresp        <= RESP_OKAY;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            id_q     <= awid;
            index    <= awaddr[SIZE_LOG +: AW];
            len_q    <= awlen;
            burst_q  <= awburst;
            err_q    <= aw_err;
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            if (beat_err) begin
              err_q <= 1'b1;
            end
            // The index is AW bits wide, so INCR wraps at MEM_DEPTH for free.
            if (burst_q == BURST_INCR) begin
              index <= index + AW'(1);
            end
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              bid   <= id_q;
              bresp <= beat_err ? RESP_SLVERR : RESP_OKAY;
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte-lane write into the array. The array has no reset so words written
  // before a reset survive it.
  always_ff @(posedge aclk) begin
    if (write_en) begin
      for (int i = 0; i < STRB; i++) begin
        if (wstrb[i]) begin
          mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Plain asynchronous array read: a same-cycle write is seen only after the
  // clock edge, so the reader gets the old word during the write cycle.
  assign mem_rdata = mem[mem_raddr];

endmodule

// File: tb/tb_axi4_wr_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi4_wr_slave_mem
//
// Self-checking bench for axi4_wr_slave_mem with default parameters
// (ID 4, ADDR 32, DATA 64, DEPTH 256). A reference memory is updated from the
// burst rules with plain arithmetic; DUT memory is read through the backdoor.
// All stimulus is driven and all outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi4_wr_slave_mem;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [7:0]  mem_raddr = '0;
  logic [63:0] mem_rdata;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [63:0] ref_mem [256];
  logic [63:0] q_data [$];
  logic [7:0]  q_strb [$];
  logic        q_last [$];
  logic [63:0] pre_hs_rdata;

  axi4_wr_slave_mem dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .awvalid   (awvalid),
    .awready   (awready),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .bid       (bid),
    .bresp     (bresp),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  always #5 aclk = ~aclk;

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Fill the beat queues for a burst of len+1 beats with correct wlast.
  task automatic fill_beats(input int len, input bit random_strb);
    q_data.delete();
    q_strb.delete();
    q_last.delete();
    for (int k = 0; k <= len; k++) begin
      q_data.push_back({$urandom, $urandom});
      q_strb.push_back(random_strb ? 8'($urandom) : 8'hFF);
      q_last.push_back(k == len);
    end
  endtask

  // Reference model: apply the first 'beats' beats of a burst to ref_mem.
  task automatic model_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int beats, output logic [1:0] resp);
    int idx;
    bit err;
    logic [7:0]  s;
    logic [63:0] d;
    err = (size != 3'd3) || (burst == 2'b10) || (burst == 2'b11);
    idx = int'(addr / 32'd8) % 256;
    for (int k = 0; k < beats; k++) begin
`ifdef AXI4_WR_SLAVE_WLAST_CHK_EN
      if (q_last[k] != (k == int'(len))) err = 1'b1;
`endif
      s = q_strb[k];
      d = q_data[k];
      if (!err) begin
        for (int b = 0; b < 8; b++) begin
          if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end
      end
      if (burst == 2'b01) idx = (idx + 1) % 256;
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  // Drive one burst from the beat queues with random W gaps. Stops after
  // abort_after beats when abort_after >= 0. Called and returns on a negedge.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int abort_after,
                           input bit do_b, output logic [3:0] got_id,
                           output logic [1:0] got_resp, output logic b_prompt,
                           output logic idle_after);
    int n;
    got_id = 'x;
    got_resp = 'x;
    b_prompt = 1'b0;
    idle_after = 1'b0;
    awid = id;
    awaddr = addr;
    awlen = len;
    awsize = size;
    awburst = burst;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (!awready) begin
      n_compared++; n_mismatched++;
      $display("[TB] FAIL aw_timeout: awready=%b, required 1", awready);
      awvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if (abort_after >= 0 && k == abort_after) return;
      repeat ($urandom_range(0, 2)) @(negedge aclk);
      wdata = q_data[k];
      wstrb = q_strb[k];
      wlast = q_last[k];
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (!wready) begin
        n_compared++; n_mismatched++;
        $display("[TB] FAIL w_timeout beat %0d: wready=%b, required 1", k, wready);
        wvalid = 1'b0;
        return;
      end
      pre_hs_rdata = mem_rdata;
      @(negedge aclk);
      wvalid = 1'b0;
    end
    b_prompt = bvalid;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!bvalid) begin
      n_compared++; n_mismatched++;
      $display("[TB] FAIL b_timeout: bvalid=%b, required 1", bvalid);
      return;
    end
    got_id = bid;
    got_resp = bresp;
    if (do_b) begin
      repeat ($urandom_range(0, 3)) @(negedge aclk);
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      idle_after = awready && !bvalid;
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    repeat (3) @(negedge aclk);
    n_compared++;
    if (awready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_awready: got %b want 0", awready); end
    n_compared++;
    if (wready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wready: got %b want 0", wready); end
    n_compared++;
    if (bvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_bvalid: got %b want 0", bvalid); end
    n_compared++;
    if (bid !== 4'h0 || bresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_b: got bid=%h bresp=%b want 0/00", bid, bresp); end
    areset_n = 1'b1;
    @(negedge aclk);
    n_compared++;
    if (awready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_awready: got %b want 1", awready); end
  endtask

  // Full-depth INCR burst from word 0 (awlen=255) to give every word a value.
  task automatic test_fill();
    logic [3:0] gid; logic [1:0] gresp, eresp; logic bp, idl;
    fill_beats(255, 1'b0);
    run_burst(4'h1, 32'h0, 8'd255, 3'd3, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h0, 8'd255, 3'd3, 2'b01, 256, eresp);
    n_compared++;
    if (gid !== 4'h1 || gresp !== eresp) begin n_mismatched++; $display("[TB] FAIL fill_b: got %h/%b want 1/%b", gid, gresp, eresp); end
    n_compared++;
    if (bp !== 1'b1 || idl !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fill_timing: got prompt=%b idle=%b want 1/1", bp, idl); end
    for (int i = 0; i < 256; i++) begin
      mem_raddr = 8'(i);
      #1;
      n_compared++;
      if (mem_rdata !== ref_mem[i]) begin n_mismatched++; $display("[TB] FAIL fill_mem[%0d]: got %h want %h", i, mem_rdata, ref_mem[i]); end
    end
    @(negedge aclk);
  endtask

  task automatic test_single_beat();
    logic [3:0] gid; logic [1:0] gresp, eresp; logic bp, idl;
    logic [63:0] old;
    old = ref_mem[2];
    mem_raddr = 8'd2;
    fill_beats(0, 1'b0);
    q_data[0] = 64'h1122334455667788;
    run_burst(4'h5, 32'h10, 8'd0, 3'd3, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h10, 8'd0, 3'd3, 2'b01, 1, eresp);
    n_compared++;
    if (gid !== 4'h5 || gresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL single_b: got %h/%b want 5/00", gid, gresp); end
    n_compared++;
    if (bp !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_latency: bvalid after last beat %b want 1", bp); end
    n_compared++;
    if (pre_hs_rdata !== old) begin n_mismatched++; $display("[TB] FAIL same_cycle_read: got %h want old %h", pre_hs_rdata, old); end
    n_compared++;
    if (mem_rdata !== 64'h1122334455667788) begin n_mismatched++; $display("[TB] FAIL single_mem: got %h want 1122334455667788", mem_rdata); end
  endtask

  // INCR burst wrapping from word 254 to 1, with bready held off for 4 cycles.
  task automatic test_bready_hold();
    logic [3:0] gid; logic [1:0] gresp, eresp; logic bp, idl;
    logic [7:0] w;
    fill_beats(3, 1'b0);
    run_burst(4'h9, 32'h7F0, 8'd3, 3'd3, 2'b01, -1, 1'b0, gid, gresp, bp, idl);
    model_burst(32'h7F0, 8'd3, 3'd3, 2'b01, 4, eresp);
    for (int h = 0; h < 4; h++) begin
      n_compared++;
      if (bvalid !== 1'b1 || bid !== 4'h9 || bresp !== 2'b00) begin
        n_mismatched++;
        $display("[TB] FAIL hold_stable cycle %0d: got v=%b id=%h r=%b want 1/9/00", h, bvalid, bid, bresp);
      end
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    n_compared++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_release: got bvalid=%b awready=%b want 0/1", bvalid, awready); end
    for (int k = 0; k < 4; k++) begin
      w = 8'(254 + k);
      mem_raddr = w;
      #1;
      n_compared++;
      if (mem_rdata !== q_data[k]) begin n_mismatched++; $display("[TB] FAIL hold_mem[%0d]: got %h want %h", w, mem_rdata, q_data[k]); end
    end
    mem_raddr = 8'd2;
    #1;
    n_compared++;
    if (mem_rdata !== ref_mem[2]) begin n_mismatched++; $display("[TB] FAIL hold_mem_untouched[2]: got %h want %h", mem_rdata, ref_mem[2]); end
    @(negedge aclk);
  endtask

  task automatic test_partial_strobe();
    logic [3:0] gid; logic [1:0] gresp, eresp; logic bp, idl;
    fill_beats(0, 1'b0);
    q_data[0] = '1;
    run_burst(4'h2, 32'h20, 8'd0, 3'd3, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h20, 8'd0, 3'd3, 2'b01, 1, eresp);
    q_data[0] = '0;
    q_strb[0] = 8'h0F;
    run_burst(4'h3, 32'h20, 8'd0, 3'd3, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h20, 8'd0, 3'd3, 2'b01, 1, eresp);
    n_compared++;
    if (gresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL strobe_resp: got %b want 00", gresp); end
    mem_raddr = 8'd4;
    #1;
    n_compared++;
    if (mem_rdata !== 64'hFFFFFFFF00000000) begin n_mismatched++; $display("[TB] FAIL strobe_mem: got %h want ffffffff00000000", mem_rdata); end
    @(negedge aclk);
  endtask

  task automatic test_errors();
    logic [3:0] gid; logic [1:0] gresp, eresp; logic bp, idl;
    logic [63:0] w8, w9;
    w8 = ref_mem[8];
    w9 = ref_mem[9];
    // Narrow size, then WRAP burst: both consumed, nothing written.
    fill_beats(1, 1'b0);
    run_burst(4'h6, 32'h40, 8'd1, 3'd2, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h40, 8'd1, 3'd2, 2'b01, 2, eresp);
    n_compared++;
    if (gid !== 4'h6 || gresp !== 2'b10) begin n_mismatched++; $display("[TB] FAIL err_size_b: got %h/%b want 6/10", gid, gresp); end
    fill_beats(1, 1'b0);
    run_burst(4'h7, 32'h40, 8'd1, 3'd3, 2'b10, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h40, 8'd1, 3'd3, 2'b10, 2, eresp);
    n_compared++;
    if (gid !== 4'h7 || gresp !== 2'b10) begin n_mismatched++; $display("[TB] FAIL err_wrap_b: got %h/%b want 7/10", gid, gresp); end
    mem_raddr = 8'd8;
    #1;
    n_compared++;
    if (mem_rdata !== w8) begin n_mismatched++; $display("[TB] FAIL err_mem[8]: got %h want %h", mem_rdata, w8); end
    mem_raddr = 8'd9;
    #1;
    n_compared++;
    if (mem_rdata !== w9) begin n_mismatched++; $display("[TB] FAIL err_mem[9]: got %h want %h", mem_rdata, w9); end
    @(negedge aclk);
    // FIXED burst of 3 beats: only the last beat remains in word 10.
    fill_beats(2, 1'b0);
    run_burst(4'h8, 32'h50, 8'd2, 3'd3, 2'b00, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h50, 8'd2, 3'd3, 2'b00, 3, eresp);
    n_compared++;
    if (gresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL fixed_resp: got %b want 00", gresp); end
    mem_raddr = 8'd10;
    #1;
    n_compared++;
    if (mem_rdata !== q_data[2]) begin n_mismatched++; $display("[TB] FAIL fixed_mem[10]: got %h want %h", mem_rdata, q_data[2]); end
    mem_raddr = 8'd11;
    #1;
    n_compared++;
    if (mem_rdata !== ref_mem[11]) begin n_mismatched++; $display("[TB] FAIL fixed_mem[11]: got %h want %h", mem_rdata, ref_mem[11]); end
    @(negedge aclk);
  endtask

  // W traffic in IDLE and AW traffic in DATA must not handshake.
  task automatic test_ignore();
    logic [1:0] eresp;
    int n;
    wdata = {$urandom, $urandom};
    wstrb = 8'hFF;
    wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_compared++;
      if (wready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_wready cycle %0d: got %b want 0", c, wready); end
      @(negedge aclk);
    end
    wvalid = 1'b0;
    awid = 4'hA; awaddr = 32'h300; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awid = 4'h3;
    awaddr = 32'h0;
    for (int c = 0; c < 2; c++) begin
      n_compared++;
      if (awready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL data_awready cycle %0d: got %b want 0", c, awready); end
      @(negedge aclk);
    end
    awvalid = 1'b0;
    fill_beats(0, 1'b0);
    wdata = q_data[0]; wstrb = q_strb[0]; wlast = 1'b1;
    wvalid = 1'b1;
    n = 0;
    while (!wready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    wvalid = 1'b0;
    n_compared++;
    if (bvalid !== 1'b1 || bid !== 4'hA || bresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL ignore_b: got v=%b id=%h r=%b want 1/a/00", bvalid, bid, bresp); end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    model_burst(32'h300, 8'd0, 3'd3, 2'b01, 1, eresp);
    for (int i = 0; i < 256; i++) begin
      mem_raddr = 8'(i);
      #1;
      n_compared++;
      if (mem_rdata !== ref_mem[i]) begin n_mismatched++; $display("[TB] FAIL ignore_mem[%0d]: got %h want %h", i, mem_rdata, ref_mem[i]); end
    end
    @(negedge aclk);
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] gid; logic [1:0] gresp, eresp; logic bp, idl;
    int quiet;
    fill_beats(3, 1'b0);
    run_burst(4'hC, 32'hA0, 8'd3, 3'd3, 2'b01, 2, 1'b0, gid, gresp, bp, idl);
    model_burst(32'hA0, 8'd3, 3'd3, 2'b01, 2, eresp);
    areset_n = 1'b0;
    @(negedge aclk);
    n_compared++;
    if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_outputs: got w=%b b=%b aw=%b want 0/0/0", wready, bvalid, awready);
    end
    @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    n_compared++;
    if (awready !== 1'b1 || bid !== 4'h0) begin n_mismatched++; $display("[TB] FAIL midrst_release: got aw=%b bid=%h want 1/0", awready, bid); end
    quiet = 0;
    for (int c = 0; c < 5; c++) begin
      if (bvalid !== 1'b0) quiet++;
      @(negedge aclk);
    end
    n_compared++;
    if (quiet != 0) begin n_mismatched++; $display("[TB] FAIL midrst_no_b: bvalid high in %0d cycles, want 0", quiet); end
    for (int i = 20; i < 24; i++) begin
      mem_raddr = 8'(i);
      #1;
      n_compared++;
      if (mem_rdata !== ref_mem[i]) begin n_mismatched++; $display("[TB] FAIL midrst_mem[%0d]: got %h want %h", i, mem_rdata, ref_mem[i]); end
    end
    @(negedge aclk);
    fill_beats(1, 1'b1);
    run_burst(4'h7, 32'hB0, 8'd1, 3'd3, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'hB0, 8'd1, 3'd3, 2'b01, 2, eresp);
    n_compared++;
    if (gid !== 4'h7 || gresp !== 2'b00 || idl !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_next: got %h/%b idle=%b want 7/00/1", gid, gresp, idl); end
  endtask

  // wlast raised on beat 0 of a 2-beat burst.
  task automatic test_wlast();
    logic [3:0] gid; logic [1:0] gresp, eresp, want;
    logic bp, idl;
`ifdef AXI4_WR_SLAVE_WLAST_CHK_EN
    want = 2'b10;
`else
    want = 2'b00;
`endif
    fill_beats(1, 1'b0);
    q_last[0] = 1'b1;
    run_burst(4'h3, 32'h100, 8'd1, 3'd3, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h100, 8'd1, 3'd3, 2'b01, 2, eresp);
    n_compared++;
    if (gid !== 4'h3 || gresp !== want) begin n_mismatched++; $display("[TB] FAIL wlast_b: got %h/%b want 3/%b", gid, gresp, want); end
    for (int i = 32; i < 34; i++) begin
      mem_raddr = 8'(i);
      #1;
      n_compared++;
      if (mem_rdata !== ref_mem[i]) begin n_mismatched++; $display("[TB] FAIL wlast_mem[%0d]: got %h want %h", i, mem_rdata, ref_mem[i]); end
    end
    @(negedge aclk);
  endtask

  // Maximum-length INCR burst starting at word 200, wrapping through 0.
  task automatic test_long_wrap();
    logic [3:0] gid; logic [1:0] gresp, eresp; logic bp, idl;
    fill_beats(255, 1'b1);
    run_burst(4'hE, 32'h640, 8'd255, 3'd3, 2'b01, -1, 1'b1, gid, gresp, bp, idl);
    model_burst(32'h640, 8'd255, 3'd3, 2'b01, 256, eresp);
    n_compared++;
    if (gid !== 4'hE || gresp !== eresp || bp !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_b: got %h/%b prompt=%b want e/%b/1", gid, gresp, bp, eresp); end
  endtask

  task automatic test_random();
    logic [3:0] id, gid; logic [1:0] gresp, eresp, burst; logic bp, idl;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size;
    int r;
    for (int t = 0; t < 25; t++) begin
      id = 4'($urandom);
      addr = $urandom;
      len = 8'($urandom_range(0, 15));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd3;
      r = $urandom_range(0, 7);
      burst = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : 2'($urandom_range(2, 3));
      fill_beats(int'(len), 1'b1);
      run_burst(id, addr, len, size, burst, -1, 1'b1, gid, gresp, bp, idl);
      model_burst(addr, len, size, burst, int'(len) + 1, eresp);
      n_compared++;
      if (gid !== id || gresp !== eresp) begin n_mismatched++; $display("[TB] FAIL rand_b %0d: got %h/%b want %h/%b", t, gid, gresp, id, eresp); end
      n_compared++;
      if (bp !== 1'b1 || idl !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rand_timing %0d: got prompt=%b idle=%b want 1/1", t, bp, idl); end
    end
    for (int i = 0; i < 256; i++) begin
      mem_raddr = 8'(i);
      #1;
      n_compared++;
      if (mem_rdata !== ref_mem[i]) begin n_mismatched++; $display("[TB] FAIL rand_mem[%0d]: got %h want %h", i, mem_rdata, ref_mem[i]); end
    end
    @(negedge aclk);
  endtask

  initial begin
    $display("[TB] starting axi4_wr_slave_mem bench");
    test_reset();
    test_fill();
    test_single_beat();
    test_bready_hold();
    test_partial_strobe();
    test_errors();
    test_ignore();
    test_reset_mid_burst();
    test_wlast();
    test_long_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
